fpro_bus_initiator: RTL and testbench
=====================================

// Module: fpro_bus_initiator
// PURPOSE
//  FPro MMIO bus initiator: accepts read/write commands on a valid/ready port, queues them
//  in a FIFO and issues each one as a single-cycle FPro bus transaction
//  (mmio_cs/wr/rd/addr/wr_data, with mmio_rd_data returned).
//  Read results return on a valid/ready response port. Drives the same bus the MMIO
//  subsystem consumes; used by a UART command bridge / DMA-style test master in place of the CPU.
// PARAMETERS
//  FIFO_AW   2    command FIFO depth = 2**FIFO_AW entries (1..5)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-high reset
//  cmd_valid     in   1   command present
//  cmd_ready     out  1   FIFO not full; command accepted when cmd_valid&&cmd_ready at a rising edge
//  cmd_wr        in   1   1=write, 0=read
//  cmd_addr      in   21  word address; [10:5]=slot, [4:0]=register
//  cmd_wdata     in   32  write data (ignored for reads)
//  rsp_valid     out  1   read data held valid
//  rsp_ready     in   1   consumer takes rsp_data at a rising edge when rsp_valid&&rsp_ready
//  rsp_data      out  32  captured mmio_rd_data
//  busy          out  1   FIFO non-empty or FSM not IDLE
//  pending       out  FIFO_AW+1  current FIFO occupancy
//  mmio_cs       out  1   bus chip select (registered)
//  mmio_wr       out  1   bus write strobe (registered)
//  mmio_rd       out  1   bus read strobe (registered)
//  mmio_addr     out  21  bus address (registered)
//  mmio_wr_data  out  32  bus write data (registered)
//  mmio_rd_data  in   32  bus read data, valid combinationally in the strobe cycle
// BEHAVIOUR
//  Reset: FIFO empty, pending=0, FSM=IDLE, every bus output 0, rsp_valid=0, rsp_data=0.
//   busy=0. cmd_ready=1 once reset is released.
//  cmd_ready = !full. It depends only on registered state; there is no combinational path
//   from the pop side. Push when full is impossible. No bypass path exists; a push into an
//   empty FIFO is visible to the FSM the next cycle.
//  Push and pop in the same cycle: occupancy is unchanged and both take effect. Pointers are
//   FIFO_AW bits and wrap modulo depth.
//  FSM:
//   IDLE:  if FIFO non-empty, pop the head, register addr/wdata/wr, go to ISSUE.
//   ISSUE: mmio_cs=1 and exactly one of mmio_wr/mmio_rd=1, for exactly one cycle.
//          Read: capture mmio_rd_data into rsp_data at the end of this cycle,
//          set rsp_valid, go to RSP.
//          Write: go to IDLE.
//   RSP:   hold rsp_valid and rsp_data stable until rsp_ready, then clear rsp_valid and
//          go to IDLE.
//  All bus outputs are 0 outside ISSUE, including addr and wr_data, so no stale value shows.
//  Latency from the cmd handshake edge E: strobe high in cycle E+2 (the cycle following the
//   second edge after E); rsp_valid rises at edge E+3.
//  Throughput is 1 op per 2 cycles for writes, and 3 cycles minimum for reads
//   (rsp_ready held 1).
//  Ordering is strict FIFO: a write queued behind a read is not issued until that read's
//   response is accepted.
//  An asserted reset mid-transaction drops bus strobes and rsp_valid immediately. Queued
//   commands are discarded.
// TESTING
//  1 reset: assert reset mid-ISSUE -> mmio_cs/wr/rd=0 and rsp_valid=0 asynchronously;
//    pending=0 and cmd_ready=1 after release.
//  2 write: cmd wr addr=0x00040 (slot 2 reg 0) data=0x000000A5 -> one cycle with cs=1,
//    wr=1, rd=0, addr=0x00040, wr_data=0xA5 at E+2. No rsp_valid.
//  3 read: bus model returns 0x12345678 for addr=0x00060 -> single rd strobe at E+2;
//    rsp_valid at E+3 with rsp_data=0x12345678. Unused slot 0x00A00 returns 0xFFFFFFFF.
//  4 backpressure: read with rsp_ready=0 for 10 cycles, then queue 2 writes -> no further
//    strobe; rsp_data stable. After rsp_ready=1, both writes issue in order.
//  5 full: push 2**FIFO_AW cmds while FSM is stalled in RSP -> cmd_ready=0 and pending=4.
//    Extra valid is not accepted. Simultaneous push and pop keeps pending constant.
//  6 stream: 64 random mixed cmds with random rsp_ready -> bus op sequence and read data
//    match a scoreboard. Exactly one strobe per cmd; pointers wrap several times.

Source files
------------

// File: rtl/fpro_bus_initiator.sv
// rtl/fpro_bus_initiator.sv - FPro MMIO bus initiator: command FIFO feeding single-cycle bus transactions
`timescale 1ns/1ps
module fpro_bus_initiator #(
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wr,
    input  logic [20:0]        cmd_addr,
    input  logic [31:0]        cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_data,
    output logic               busy,
    output logic [FIFO_AW:0]   pending,
    output logic               mmio_cs,
    output logic               mmio_wr,
    output logic               mmio_rd,
    output logic [20:0]        mmio_addr,
    output logic [31:0]        mmio_wr_data,
    input  logic [31:0]        mmio_rd_data
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef struct packed {
        logic        wr;
        logic [20:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RSP
    } state_t;

    cmd_t               fifo_mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    cmd_t               head;

    state_t             state_q;
    state_t             state_d;
    cmd_t               op_q;
    cmd_t               op_d;

    logic               cs_q;
    logic               cs_d;
    logic               wr_q;
    logic               wr_d;
    logic               rd_q;
    logic               rd_d;
    logic [20:0]        addr_q;
    logic [20:0]        addr_d;
    logic [31:0]        wdata_q;
    logic [31:0]        wdata_d;
    logic               rsp_valid_q;
    logic               rsp_valid_d;
    logic [31:0]        rsp_data_q;
    logic [31:0]        rsp_data_d;

    // Occupancy reaches exactly DEPTH when full, so its top bit is the full flag.
    assign fifo_full  = count_q[FIFO_AW];
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_wr, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Accepting a response may pop the next command directly so reads sustain one per 3 cycles.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    op_d    = head;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = op_q.wr ? S_IDLE : S_RSP;
            end
            S_RSP: begin
                if (rsp_valid_q && rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        op_d    = head;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus registers load from ISSUE, so the strobe cycle directly follows it; idle bus is all zero.
    always_comb begin
        cs_d        = (state_q == S_ISSUE);
        wr_d        = cs_d && op_q.wr;
        rd_d        = cs_d && !op_q.wr;
        addr_d      = cs_d ? op_q.addr : '0;
        wdata_d     = wr_d ? op_q.wdata : '0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (rd_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mmio_rd_data;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign mmio_cs      = cs_q;
    assign mmio_wr      = wr_q;
    assign mmio_rd      = rd_q;
    assign mmio_addr    = addr_q;
    assign mmio_wr_data = wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign pending      = count_q;
    assign busy         = !fifo_empty || (state_q != S_IDLE) || cs_q;

endmodule

// File: tb/tb_fpro_bus_initiator.sv
// tb/tb_fpro_bus_initiator.sv - self-checking bench for fpro_bus_initiator
`timescale 1ns/1ps
module tb_fpro_bus_initiator;

    localparam int FIFO_AW = 2;

    typedef struct packed {
        logic        wr;
        logic [20:0] addr;
        logic [31:0] wdata;
    } op_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_wr = 1'b0;
    logic [20:0]        cmd_addr = '0;
    logic [31:0]        cmd_wdata = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [31:0]        rsp_data;
    logic               busy;
    logic [FIFO_AW:0]   pending;
    logic               mmio_cs;
    logic               mmio_wr;
    logic               mmio_rd;
    logic [20:0]        mmio_addr;
    logic [31:0]        mmio_wr_data;
    logic [31:0]        mmio_rd_data = '0;

    fpro_bus_initiator #(.FIFO_AW(FIFO_AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_wr       (cmd_wr),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .pending      (pending),
        .mmio_cs      (mmio_cs),
        .mmio_wr      (mmio_wr),
        .mmio_rd      (mmio_rd),
        .mmio_addr    (mmio_addr),
        .mmio_wr_data (mmio_wr_data),
        .mmio_rd_data (mmio_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_strobe = 0;
    bit          mon_en = 0;
    bit          rand_rdy = 0;
    bit          rd_outstanding = 0;
    bit          prev_hold = 0;
    logic [31:0] hold_data = '0;
    int          sidx;

    logic [20:0] pool [8];
    logic [31:0] ref_mem [8];
    logic [31:0] slave_mem [8];
    op_t         exp_ops [$];
    logic [31:0] exp_rsp [$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pool_idx(input logic [20:0] a);
        for (int i = 0; i < 8; i++) begin
            if (pool[i] == a) return i;
        end
        return -1;
    endfunction

    // Bus target: small register file, unmapped addresses read as all ones.
    always @(negedge clk) begin
        if (mmio_cs && mmio_wr) begin
            sidx = pool_idx(mmio_addr);
            if (sidx >= 0) slave_mem[sidx] = mmio_wr_data;
        end
        if (mmio_cs && mmio_rd) begin
            sidx = pool_idx(mmio_addr);
            mmio_rd_data = (sidx >= 0) ? slave_mem[sidx] : 32'hFFFF_FFFF;
        end else begin
            mmio_rd_data = '0;
        end
    end

    // Reference model: ops in command order, read data from the command-order register image.
    task automatic sb_push(input logic wr, input logic [20:0] addr, input logic [31:0] wd);
        op_t o;
        int  i;
        o.wr = wr;
        o.addr = addr;
        o.wdata = wd;
        exp_ops.push_back(o);
        i = pool_idx(addr);
        if (wr) begin
            if (i >= 0) ref_mem[i] = wd;
        end else begin
            exp_rsp.push_back((i >= 0) ? ref_mem[i] : 32'hFFFF_FFFF);
        end
    endtask

    always @(negedge clk) begin
        if (!mon_en || reset) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check_eq("rsp_hold_valid", rsp_valid, 1);
                check_eq("rsp_hold_data", rsp_data, hold_data);
            end
            if (mmio_cs) begin
                n_strobe++;
                check_eq("order_after_read", rd_outstanding, 0);
                check_eq("strobe_has_cmd", exp_ops.size() > 0, 1);
                if (exp_ops.size() > 0) begin
                    op_t o;
                    o = exp_ops.pop_front();
                    check_eq("bus_wr", mmio_wr, o.wr);
                    check_eq("bus_rd", mmio_rd, !o.wr);
                    check_eq("bus_addr", mmio_addr, o.addr);
                    if (o.wr) check_eq("bus_wdata", mmio_wr_data, o.wdata);
                end
                if (mmio_rd) rd_outstanding = 1;
            end else begin
                check_eq("bus_idle_zero", {mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}, 0);
            end
            if (rsp_valid && rsp_ready) begin
                check_eq("rsp_has_read", exp_rsp.size() > 0, 1);
                if (exp_rsp.size() > 0) check_eq("rsp_data", rsp_data, exp_rsp.pop_front());
                rd_outstanding = 0;
            end
            prev_hold = rsp_valid && !rsp_ready;
            hold_data = rsp_data;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic sync_drive();
        @(posedge clk);
        #1;
    endtask

    // Must be entered just after a rising edge; returns just after the handshake edge.
    task automatic send_cmd(input logic wr, input logic [20:0] addr, input logic [31:0] wd, output int e);
        bit got = 0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = cmd_ready;
        end
        check_eq("cmd_accept_timeout", got, 1);
        if (got) begin
            @(posedge clk);
            sb_push(wr, addr, wd);
        end
        #1;
        cmd_valid = 1'b0;
        e = cyc;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        bit done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            done = !busy && (exp_ops.size() == 0) && (exp_rsp.size() == 0);
        end
        check_eq(tag, done, 1);
    endtask

    initial begin
        int e;
        int s0;
        pool[0] = 21'h00040; pool[1] = 21'h00060; pool[2] = 21'h00080; pool[3] = 21'h00A00;
        pool[4] = 21'h0001F; pool[5] = 21'h007FF; pool[6] = 21'h1FFFFF; pool[7] = 21'h10ABC;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i]   = 32'hFFFF_FFFF;
            slave_mem[i] = 32'hFFFF_FFFF;
        end
        ref_mem[1]   = 32'h1234_5678;
        slave_mem[1] = 32'h1234_5678;

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_bus", {mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}, 0);
        check_eq("reset_rsp", {rsp_valid, rsp_data}, 0);
        check_eq("reset_pending", pending, 0);
        check_eq("reset_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("release_cmd_ready", cmd_ready, 1);
        mon_en = 1;
        sync_drive();

        // Single write: strobe only in the cycle after the second edge following the handshake.
        rsp_ready = 1'b1;
        send_cmd(1'b1, 21'h00040, 32'h0000_00A5, e);
        @(negedge clk);
        check_eq("wr_lat_e0_cs", mmio_cs, 0);
        @(negedge clk);
        check_eq("wr_lat_e1_cs", mmio_cs, 0);
        @(negedge clk);
        check_eq("wr_strobe", {mmio_cs, mmio_wr, mmio_rd}, 3'b110);
        check_eq("wr_addr", mmio_addr, 21'h00040);
        check_eq("wr_data", mmio_wr_data, 32'h0000_00A5);
        @(negedge clk);
        check_eq("wr_strobe_one_cycle", mmio_cs, 0);
        check_eq("wr_no_rsp", rsp_valid, 0);
        wait_idle("wr_idle", 50);

        // Reads: mapped register and unmapped slot.
        sync_drive();
        send_cmd(1'b0, 21'h00060, 32'h0, e);
        repeat (2) @(negedge clk);
        check_eq("rd_pre_cs", mmio_cs, 0);
        @(negedge clk);
        check_eq("rd_strobe", {mmio_cs, mmio_wr, mmio_rd}, 3'b101);
        check_eq("rd_addr", mmio_addr, 21'h00060);
        check_eq("rd_rsp_not_yet", rsp_valid, 0);
        @(negedge clk);
        check_eq("rd_rsp_valid", rsp_valid, 1);
        check_eq("rd_rsp_data", rsp_data, 32'h1234_5678);
        wait_idle("rd_idle", 50);
        sync_drive();
        send_cmd(1'b0, 21'h00A00, 32'h0, e);
        repeat (4) @(negedge clk);
        check_eq("rd_unmapped_data", rsp_data, 32'hFFFF_FFFF);
        wait_idle("rd2_idle", 50);

        // Backpressure, then fill the FIFO behind the stalled response.
        sync_drive();
        rsp_ready = 1'b0;
        send_cmd(1'b0, 21'h00060, 32'h0, e);
        repeat (10) @(negedge clk);
        check_eq("bp_rsp_valid", rsp_valid, 1);
        check_eq("bp_rsp_data", rsp_data, 32'h1234_5678);
        check_eq("bp_busy", busy, 1);
        s0 = n_strobe;
        sync_drive();
        send_cmd(1'b1, 21'h00040, 32'h1111_1111, e);
        send_cmd(1'b1, 21'h00080, 32'h2222_2222, e);
        repeat (5) @(negedge clk);
        check_eq("bp_no_strobe", n_strobe, s0);
        check_eq("bp_pending2", pending, 2);
        sync_drive();
        send_cmd(1'b1, 21'h0001F, 32'h3333_3333, e);
        send_cmd(1'b0, 21'h00040, 32'h0, e);
        @(negedge clk);
        check_eq("full_cmd_ready", cmd_ready, 0);
        check_eq("full_pending", pending, 4);
        sync_drive();
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 21'h007FF;
        cmd_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("full_extra_ready", cmd_ready, 0);
            check_eq("full_extra_pending", pending, 4);
        end
        sync_drive();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("bp_drain_idle", 100);
        check_eq("bp_drain_strobes", n_strobe, s0 + 4);

        // Push while the FSM pops the previous head: occupancy stays at one.
        sync_drive();
        send_cmd(1'b1, 21'h10ABC, 32'h5555_AAAA, e);
        send_cmd(1'b1, 21'h1FFFFF, 32'hA5A5_0F0F, e);
        @(negedge clk);
        check_eq("pushpop_pending", pending, 1);
        wait_idle("pushpop_idle", 50);
        check_eq("pushpop_pending_end", pending, 0);

        // Reset in the middle of a read strobe with a write still queued.
        sync_drive();
        send_cmd(1'b0, 21'h00060, 32'h0, e);
        send_cmd(1'b1, 21'h155555, 32'h7777_7777, e);
        repeat (2) @(negedge clk);
        check_eq("rst_pre_cs", mmio_cs, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_async_strobe", {mmio_cs, mmio_wr, mmio_rd}, 0);
        check_eq("rst_async_rsp_valid", rsp_valid, 0);
        check_eq("rst_pending", pending, 0);
        mon_en = 0;
        exp_ops.delete();
        exp_rsp.delete();
        rd_outstanding = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mon_en = 1;
        @(negedge clk);
        check_eq("rst_rel_cmd_ready", cmd_ready, 1);
        check_eq("rst_rel_pending", pending, 0);
        check_eq("rst_rel_busy", busy, 0);
        repeat (3) @(negedge clk);
        check_eq("rst_discard_no_strobe", mmio_cs, 0);

        // Random mixed stream with random response backpressure.
        sync_drive();
        s0 = n_strobe;
        rand_rdy = 1;
        for (int n = 0; n < 64; n++) begin
            logic        w;
            int          idx;
            int          gap;
            w   = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 7);
            if (w && idx == 3) idx = 4;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send_cmd(w, pool[idx], $urandom, e);
        end
        rand_rdy = 0;
        @(posedge clk);
        #2 rsp_ready = 1'b1;
        wait_idle("stream_idle", 2000);
        check_eq("stream_strobes", n_strobe - s0, 64);
        check_eq("stream_pending_end", pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
